hc_host_mem_responder: RTL and testbench

- FIU-side responder for the CCI-P request channels that our requestor blocks drive: accepts c0 line reads and c1 line writes, then returns read responses and write acks on the matching Rx channels.
- Backed by an on-chip line memory, with per-channel almost-full back-pressure.
- Used as a synthesizable host-memory stand-in for AFU bring-up and for block-level verification of requestor logic without the platform.
- Single-line requests only.

---
 rtl/hc_mem_pkg.sv | 79 +++++++
 rtl/hc_host_mem_responder_if.sv | 14 +
 rtl/hc_req_fifo.sv | 46 ++++
 rtl/hc_host_mem_responder.sv | 102 ++++++++++
 tb/tb_hc_host_mem_responder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hc_mem_pkg.sv
// rtl/hc_mem_pkg.sv - CCI-P channel structs and request/pipeline types for the host memory responder
package hc_mem_pkg;

    localparam int HC_MEM_LINES = 1024;
    localparam int HC_IDX_W     = $clog2(HC_MEM_LINES);
    localparam int HC_ADDR_W    = 42;
    localparam int HC_MDATA_W   = 16;
    localparam int HC_DATA_W    = 512;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_WRLINE = 4'h1
    } t_ccip_rsp_type;

    typedef struct packed {
        logic [1:0]            cl_len;
        logic [HC_ADDR_W-1:0]  address;
        logic [HC_MDATA_W-1:0] mdata;
    } t_ccip_req_hdr;

    typedef struct packed {
        t_ccip_req_hdr hdr;
        logic          valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_req_hdr         hdr;
        logic [HC_DATA_W-1:0]  data;
        logic                  valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [1:0]            vc_used;
        logic                  hit_miss;
        logic [1:0]            cl_num;
        t_ccip_rsp_type        resp_type;
        logic [HC_MDATA_W-1:0] mdata;
    } t_ccip_c0_rsp_hdr;

    typedef struct packed {
        logic [1:0]            vc_used;
        logic                  hit_miss;
        logic                  format;
        logic [1:0]            cl_num;
        t_ccip_rsp_type        resp_type;
        logic [HC_MDATA_W-1:0] mdata;
    } t_ccip_c1_rsp_hdr;

    typedef struct packed {
        t_ccip_c0_rsp_hdr     hdr;
        logic [HC_DATA_W-1:0] data;
        logic                 rspValid;
        logic                 mmioRdValid;
        logic                 mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_rsp_hdr hdr;
        logic             rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic [HC_ADDR_W-1:0]  address;
        logic [HC_MDATA_W-1:0] mdata;
    } t_hc_rd_req;

    typedef struct packed {
        logic [HC_ADDR_W-1:0]  address;
        logic [HC_MDATA_W-1:0] mdata;
        logic [HC_DATA_W-1:0]  data;
    } t_hc_wr_req;

    typedef struct packed {
        logic                  valid;
        logic [HC_MDATA_W-1:0] mdata;
        logic [HC_DATA_W-1:0]  data;
    } t_hc_rd_pipe;

endpackage

// File: rtl/hc_host_mem_responder_if.sv
// rtl/hc_host_mem_responder_if.sv - CCI-P c0/c1 request and response channels between requestor and responder
interface hc_host_mem_responder_if;
    import hc_mem_pkg::*;

    t_if_ccip_c0_Tx c0_tx;
    t_if_ccip_c1_Tx c1_tx;
    t_if_ccip_c0_Rx c0_rx;
    t_if_ccip_c1_Rx c1_rx;
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;

    modport master (output c0_tx, c1_tx, input c0_rx, c1_rx, c0TxAlmFull, c1TxAlmFull);
    modport slave  (input c0_tx, c1_tx, output c0_rx, c1_rx, c0TxAlmFull, c1TxAlmFull);
endinterface

// File: rtl/hc_req_fifo.sv
// rtl/hc_req_fifo.sv - parameterized synchronous request FIFO with occupancy count
module hc_req_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  T                         data_in,
    input  logic                     pop,
    output T                         data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    T              store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push that meets a full FIFO is dropped even if a pop frees a slot that cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign data_out = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/hc_host_mem_responder.sv
// rtl/hc_host_mem_responder.sv - FIU-side CCI-P line read/write responder backed by on-chip line memory
module hc_host_mem_responder
    import hc_mem_pkg::*;
#(
    parameter int MEM_LINES     = HC_MEM_LINES,
    parameter int FIFO_DEPTH    = 16,
    parameter int ALMFULL_SLACK = 8,
    parameter int READ_LATENCY  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    hc_host_mem_responder_if.slave  host,
    // Dequeue holds; tied low in normal use, raised to build up FIFO occupancy.
    input  logic                    c0_deq_stall,
    input  logic                    c1_deq_stall,
    output logic                    err_overflow,
    output logic                    err_multiline
);
    localparam int                IDX_W      = $clog2(MEM_LINES);
    localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  ALMFULL_AT = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);

    t_hc_rd_req           rd_in, rd_head;
    t_hc_wr_req           wr_in, wr_head;
    logic                 rd_empty, rd_full, wr_empty, wr_full;
    logic                 rd_pop, wr_pop;
    logic [CNT_W-1:0]     rd_count, wr_count;
    logic [IDX_W-1:0]     rd_idx, wr_idx;
    logic [HC_DATA_W-1:0] line_mem [MEM_LINES];
    logic [HC_DATA_W-1:0] rd_data;
    t_hc_rd_pipe          rd_pipe [READ_LATENCY];
    logic                 wr_ack_valid;
    logic [HC_MDATA_W-1:0] wr_ack_mdata;
    logic                 c0_almfull, c1_almfull;
    logic                 unused_addr_bits;

    assign rd_in = '{address: host.c0_tx.hdr.address, mdata: host.c0_tx.hdr.mdata};
    assign wr_in = '{address: host.c1_tx.hdr.address, mdata: host.c1_tx.hdr.mdata,
                     data: host.c1_tx.data};

    hc_req_fifo #(.T(t_hc_rd_req), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk, .reset_n, .push(host.c0_tx.valid), .data_in(rd_in), .pop(rd_pop),
        .data_out(rd_head), .empty(rd_empty), .full(rd_full), .count(rd_count)
    );

    hc_req_fifo #(.T(t_hc_wr_req), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk, .reset_n, .push(host.c1_tx.valid), .data_in(wr_in), .pop(wr_pop),
        .data_out(wr_head), .empty(wr_empty), .full(wr_full), .count(wr_count)
    );

    assign rd_pop = !rd_empty && !c0_deq_stall;
    assign wr_pop = !wr_empty && !c1_deq_stall;
    assign rd_idx = rd_head.address[IDX_W-1:0];
    assign wr_idx = wr_head.address[IDX_W-1:0];
    assign unused_addr_bits = ^{rd_head.address[HC_ADDR_W-1:IDX_W], wr_head.address[HC_ADDR_W-1:IDX_W]};

    // Write-first: a read dequeued alongside a write to the same line sees the new data.
    assign rd_data = (wr_pop && (wr_idx == rd_idx)) ? wr_head.data : line_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_pop) line_mem[wr_idx] <= wr_head.data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] <= '0;
            wr_ack_valid  <= 1'b0;
            wr_ack_mdata  <= '0;
            c0_almfull    <= 1'b0;
            c1_almfull    <= 1'b0;
            err_overflow  <= 1'b0;
            err_multiline <= 1'b0;
        end else begin
            rd_pipe[0] <= '{valid: rd_pop, mdata: rd_head.mdata, data: rd_data};
            for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
            wr_ack_valid <= wr_pop;
            wr_ack_mdata <= wr_head.mdata;
            c0_almfull   <= (rd_count >= ALMFULL_AT);
            c1_almfull   <= (wr_count >= ALMFULL_AT);
            if ((host.c0_tx.valid && rd_full) || (host.c1_tx.valid && wr_full))
                err_overflow <= 1'b1;
            if ((host.c0_tx.valid && (host.c0_tx.hdr.cl_len != 2'd0)) ||
                (host.c1_tx.valid && (host.c1_tx.hdr.cl_len != 2'd0)))
                err_multiline <= 1'b1;
        end
    end

    always_comb begin
        host.c0_rx                = '0;
        host.c0_rx.rspValid       = rd_pipe[READ_LATENCY-1].valid;
        host.c0_rx.hdr.mdata      = rd_pipe[READ_LATENCY-1].mdata;
        host.c0_rx.hdr.resp_type  = eRSP_RDLINE;
        host.c0_rx.data           = rd_pipe[READ_LATENCY-1].data;
        host.c1_rx                = '0;
        host.c1_rx.rspValid       = wr_ack_valid;
        host.c1_rx.hdr.mdata      = wr_ack_mdata;
        host.c1_rx.hdr.resp_type  = eRSP_WRLINE;
    end

    assign host.c0TxAlmFull = c0_almfull;
    assign host.c1TxAlmFull = c1_almfull;
endmodule

// File: tb/tb_hc_host_mem_responder.sv
// tb/tb_hc_host_mem_responder.sv - self-checking bench for hc_host_mem_responder
module tb_hc_host_mem_responder;
    import hc_mem_pkg::*;

    localparam int MEM_LINES     = 1024;
    localparam int FIFO_DEPTH    = 16;
    localparam int ALMFULL_SLACK = 8;
    localparam int READ_LATENCY  = 4;

    logic clk          = 1'b0;
    logic reset_n      = 1'b0;
    logic c0_deq_stall = 1'b0;
    logic c1_deq_stall = 1'b0;
    logic err_overflow;
    logic err_multiline;

    hc_host_mem_responder_if bus();

    hc_host_mem_responder #(
        .MEM_LINES(MEM_LINES), .FIFO_DEPTH(FIFO_DEPTH),
        .ALMFULL_SLACK(ALMFULL_SLACK), .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk(clk), .reset_n(reset_n), .host(bus),
        .c0_deq_stall(c0_deq_stall), .c1_deq_stall(c1_deq_stall),
        .err_overflow(err_overflow), .err_multiline(err_multiline)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [15:0] mdata;
        logic [511:0] data;
    } t_exp_rsp;

    t_exp_rsp     rd_q[$];
    t_exp_rsp     wr_q[$];
    logic [511:0] model_mem [int];
    bit           multiline_seen = 0;

    typedef struct {
        logic        wv;
        logic [41:0] wa;
        logic [15:0] wm;
        logic [7:0]  wb;
        logic        rv;
        logic [41:0] ra;
        logic [15:0] rm;
        logic [7:0]  exp_b;
    } t_vec;

    t_vec vecs[8];

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(logic [41:0] a);
        return int'(a % 42'(MEM_LINES));
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_rd(int due, logic [15:0] m, logic [511:0] d);
        t_exp_rsp e;
        e.due = due; e.mdata = m; e.data = d;
        rd_q.push_back(e);
    endtask

    task automatic push_wr(int due, logic [15:0] m);
        t_exp_rsp e;
        e.due = due; e.mdata = m; e.data = '0;
        wr_q.push_back(e);
    endtask

    task automatic drive_rd(logic v, logic [41:0] a, logic [15:0] m, logic [1:0] cl);
        bus.c0_tx.valid       = v;
        bus.c0_tx.hdr.address = a;
        bus.c0_tx.hdr.mdata   = m;
        bus.c0_tx.hdr.cl_len  = cl;
    endtask

    task automatic drive_wr(logic v, logic [41:0] a, logic [15:0] m, logic [511:0] d, logic [1:0] cl);
        bus.c1_tx.valid       = v;
        bus.c1_tx.hdr.address = a;
        bus.c1_tx.hdr.mdata   = m;
        bus.c1_tx.hdr.cl_len  = cl;
        bus.c1_tx.data        = d;
    endtask

    task automatic idle();
        bus.c0_tx = '0;
        bus.c1_tx = '0;
    endtask

    // Reference model: a write lands before a read issued in the same cycle;
    // with empty FIFOs, ack is 2 cycles after issue and read data 1+READ_LATENCY.
    task automatic issue(logic rv, logic [41:0] ra, logic [15:0] rm, logic [1:0] rcl,
                         logic wv, logic [41:0] wa, logic [15:0] wm, logic [511:0] wd,
                         logic [1:0] wcl, bit timed);
        if (wv) begin
            model_mem[line_of(wa)] = wd;
            push_wr(timed ? cyc + 2 : -1, wm);
        end
        if (rv) push_rd(timed ? cyc + 1 + READ_LATENCY : -1, rm, model_mem[line_of(ra)]);
        if ((rv && rcl != 2'd0) || (wv && wcl != 2'd0)) multiline_seen = 1;
        drive_rd(rv, ra, rm, rcl);
        drive_wr(wv, wa, wm, wd, wcl);
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check({name, "_pending_rsp"}, 512'(rd_q.size() + wr_q.size()), 512'(0));
    endtask

    always @(negedge clk) begin : monitor
        t_exp_rsp e;
        logic     v0, v1;
        if (reset_n) begin
            v0 = bus.c0_rx.rspValid;
            v1 = bus.c1_rx.rspValid;
            if (rd_q.size() == 0) begin
                if (v0) check("c0_unexpected_rsp", v0, 1'b0);
            end else if (v0 || (rd_q[0].due >= 0 && rd_q[0].due <= cyc)) begin
                e = rd_q.pop_front();
                check("c0_rsp_valid", v0, 1'b1);
                if (v0) begin
                    if (e.due >= 0) check("c0_rsp_cycle", cyc, e.due);
                    check("c0_rsp_mdata", bus.c0_rx.hdr.mdata, e.mdata);
                    check("c0_rsp_data", bus.c0_rx.data, e.data);
                    check("c0_rsp_type", bus.c0_rx.hdr.resp_type, eRSP_RDLINE);
                    check("c0_rsp_zero_fields",
                          {bus.c0_rx.hdr.vc_used, bus.c0_rx.hdr.hit_miss, bus.c0_rx.hdr.cl_num,
                           bus.c0_rx.mmioRdValid, bus.c0_rx.mmioWrValid}, '0);
                end
            end
            if (wr_q.size() == 0) begin
                if (v1) check("c1_unexpected_ack", v1, 1'b0);
            end else if (v1 || (wr_q[0].due >= 0 && wr_q[0].due <= cyc)) begin
                e = wr_q.pop_front();
                check("c1_ack_valid", v1, 1'b1);
                if (v1) begin
                    if (e.due >= 0) check("c1_ack_cycle", cyc, e.due);
                    check("c1_ack_mdata", bus.c1_rx.hdr.mdata, e.mdata);
                    check("c1_ack_type", bus.c1_rx.hdr.resp_type, eRSP_WRLINE);
                    check("c1_ack_zero_fields",
                          {bus.c1_rx.hdr.vc_used, bus.c1_rx.hdr.hit_miss,
                           bus.c1_rx.hdr.format, bus.c1_rx.hdr.cl_num}, '0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rv, wv;
        logic [1:0]  rcl, wcl;
        logic [41:0] ra, wa;
        int          first_due;

        idle();
        reset_n = 1'b0;
        repeat (3) step();
        check("rst_c0_rspvalid", bus.c0_rx.rspValid, 1'b0);
        check("rst_c1_rspvalid", bus.c1_rx.rspValid, 1'b0);
        check("rst_c0_almfull", bus.c0TxAlmFull, 1'b0);
        check("rst_c1_almfull", bus.c1TxAlmFull, 1'b0);
        check("rst_err_overflow", err_overflow, 1'b0);
        check("rst_err_multiline", err_multiline, 1'b0);
        reset_n = 1'b1;
        step();

        // Directed vectors: one row per cycle, expected read data as constants.
        vecs[0] = '{1'b1, 42'd5,        16'h11, 8'hA5, 1'b0, 42'd0,        16'h00, 8'h00};
        vecs[1] = '{1'b0, 42'd0,        16'h00, 8'h00, 1'b1, 42'd5,        16'h22, 8'hA5};
        vecs[2] = '{1'b1, 42'd1029,     16'h12, 8'h3C, 1'b0, 42'd0,        16'h00, 8'h00};
        vecs[3] = '{1'b0, 42'd0,        16'h00, 8'h00, 1'b1, 42'd5,        16'h23, 8'h3C};
        vecs[4] = '{1'b1, 42'd9,        16'h13, 8'h00, 1'b0, 42'd0,        16'h00, 8'h00};
        vecs[5] = '{1'b1, 42'd9,        16'h14, 8'hFF, 1'b1, 42'd9,        16'h24, 8'hFF};
        vecs[6] = '{1'b0, 42'd0,        16'h00, 8'h00, 1'b1, 42'd2057,     16'h25, 8'hFF};
        vecs[7] = '{1'b1, 42'd3077,     16'h15, 8'h5A, 1'b1, 42'd5,        16'h26, 8'h5A};
        foreach (vecs[i]) begin
            if (vecs[i].wv) begin
                push_wr(cyc + 2, vecs[i].wm);
                model_mem[line_of(vecs[i].wa)] = {64{vecs[i].wb}};
            end
            if (vecs[i].rv) push_rd(cyc + 1 + READ_LATENCY, vecs[i].rm, {64{vecs[i].exp_b}});
            drive_wr(vecs[i].wv, vecs[i].wa, vecs[i].wm, {64{vecs[i].wb}}, 2'd0);
            drive_rd(vecs[i].rv, vecs[i].ra, vecs[i].rm, 2'd0);
            step();
            idle();
        end
        drain("table", 50);

        // Randomized traffic over lines 0..31 with address wrap, against the model.
        for (int i = 0; i < 32; i++) begin
            issue(1'b0, '0, '0, 2'd0, 1'b1, 42'(i), 16'(16'h100 + i), rand512(), 2'd0, 1'b1);
            step();
        end
        idle();
        drain("preload", 50);
        for (int t = 0; t < 300; t++) begin
            rv  = 1'($urandom_range(0, 1));
            wv  = 1'($urandom_range(0, 1));
            ra  = 42'($urandom_range(0, 31) + $urandom_range(0, 3) * MEM_LINES);
            wa  = 42'($urandom_range(0, 31) + $urandom_range(0, 3) * MEM_LINES);
            rcl = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            wcl = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if (t == 5) begin
                wv  = 1'b1;
                wcl = 2'd1;
            end
            issue(rv, ra, 16'($urandom), rcl, wv, wa, 16'($urandom), rand512(), wcl, 1'b1);
            step();
        end
        idle();
        drain("random", 50);
        check("err_multiline_sticky", err_multiline, multiline_seen);
        check("err_overflow_random", err_overflow, 1'b0);

        // Back-pressure: stalled dequeue fills both FIFOs, then a 17th read overflows.
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, '0, '0, 2'd0, 1'b1, 42'(200 + i), 16'(16'h200 + i), rand512(), 2'd0, 1'b1);
            step();
        end
        idle();
        drain("preload2", 50);
        c0_deq_stall = 1'b1;
        c1_deq_stall = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            issue(1'b1, 42'(200 + k - 1), 16'(16'h300 + k), 2'd0,
                  1'b1, 42'(300 + k - 1), 16'(16'h400 + k), rand512(), 2'd0, 1'b0);
            step();
            check($sformatf("c0_almfull_k%0d", k), bus.c0TxAlmFull,
                  1'((k - 1) >= (FIFO_DEPTH - ALMFULL_SLACK)));
            check($sformatf("c1_almfull_k%0d", k), bus.c1TxAlmFull,
                  1'((k - 1) >= (FIFO_DEPTH - ALMFULL_SLACK)));
            check($sformatf("no_overflow_k%0d", k), err_overflow, 1'b0);
        end
        idle();
        drive_rd(1'b1, 42'd250, 16'h3FF, 2'd0);
        step();
        idle();
        check("overflow_on_17th", err_overflow, 1'b1);
        check("c0_almfull_full", bus.c0TxAlmFull, 1'b1);
        c0_deq_stall = 1'b0;
        c1_deq_stall = 1'b0;
        drain("burst", 200);
        repeat (10) step();
        check("burst_no_extra_rsp", 512'(rd_q.size()), 512'(0));

        // Reset with reads in flight: outputs clear at once, nothing returns later.
        first_due = cyc + 1 + READ_LATENCY;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 42'(i), 16'(16'h500 + i), 2'd0, 1'b0, '0, '0, '0, 2'd0, 1'b1);
            step();
        end
        idle();
        while (cyc < first_due) step();
        check("inflight_rsp_before_reset", bus.c0_rx.rspValid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst_c0_rspvalid", bus.c0_rx.rspValid, 1'b0);
        check("async_rst_err_overflow", err_overflow, 1'b0);
        rd_q.delete();
        wr_q.delete();
        step();
        reset_n = 1'b1;
        check("post_rst_c0_almfull", bus.c0TxAlmFull, 1'b0);
        check("post_rst_c1_almfull", bus.c1TxAlmFull, 1'b0);
        check("post_rst_err_overflow", err_overflow, 1'b0);
        check("post_rst_err_multiline", err_multiline, 1'b0);
        repeat (12) step();
        issue(1'b1, 42'd0, 16'h600, 2'd0, 1'b0, '0, '0, '0, 2'd0, 1'b1);
        step();
        idle();
        drain("post_reset", 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
